// File: rtl/ifu_pkg.sv
// -----------------------------------------------------------------------------
// ifu_pkg
// Shared types and defaults for the instruction prefetch unit.
//   XLEN / ILEN / RESET_PC : default address width, instruction width and
//                            first fetch address used by the IFU blocks.
//   redir_e                : redirect cause, in priority order ex > eret > br.
//   q_entry_t              : one prefetch queue entry {pc, inst}.
//   redir_cause()          : priority encoder for the three redirect inputs.
// -----------------------------------------------------------------------------
package ifu_pkg;

   localparam int              XLEN     = 64;
   localparam int              ILEN     = 32;
   localparam logic [XLEN-1:0] RESET_PC = 64'h8000_0000;

   typedef enum logic [1:0] {
      REDIR_NONE = 2'd0,
      REDIR_BR   = 2'd1,
      REDIR_EX   = 2'd2,
      REDIR_ERET = 2'd3
   } redir_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] inst;
   } q_entry_t;

   // Exception entry wins over mret, which wins over a branch.
   function automatic redir_e redir_cause(input logic ex,
                                          input logic ex_ret,
                                          input logic br_taken);
      redir_e cause;
      cause = REDIR_NONE;
      if (ex)            cause = REDIR_EX;
      else if (ex_ret)   cause = REDIR_ERET;
      else if (br_taken) cause = REDIR_BR;
      return cause;
   endfunction

endpackage : ifu_pkg

// File: rtl/ifu_prefetch_if.sv
// -----------------------------------------------------------------------------
// Bus interfaces of the prefetch unit.
//   ifu_imem_if : instruction memory request/response port.
//      req_valid/req_ready/req_addr : request handshake (master drives valid/addr)
//      resp_valid/resp_data         : in-order response, always accepted
//   ifu_inst_if : decode-side valid/ready port.
//      inst_valid/inst/pc           : queue head (master drives)
//      inst_ready                   : decode consumes the head
// The prefetch unit is the master of both; memory and decode are slaves.
// -----------------------------------------------------------------------------
interface ifu_imem_if #(
   parameter int XLEN = ifu_pkg::XLEN,
   parameter int ILEN = ifu_pkg::ILEN
);
   logic            req_valid;
   logic            req_ready;
   logic [XLEN-1:0] req_addr;
   logic            resp_valid;
   logic [ILEN-1:0] resp_data;

   modport master (
      output req_valid, req_addr,
      input  req_ready, resp_valid, resp_data
   );

   modport slave (
      input  req_valid, req_addr,
      output req_ready, resp_valid, resp_data
   );
endinterface : ifu_imem_if

interface ifu_inst_if #(
   parameter int XLEN = ifu_pkg::XLEN,
   parameter int ILEN = ifu_pkg::ILEN
);
   logic            inst_valid;
   logic            inst_ready;
   logic [ILEN-1:0] inst;
   logic [XLEN-1:0] pc;

   modport master (
      output inst_valid, inst, pc,
      input  inst_ready
   );

   modport slave (
      input  inst_valid, inst, pc,
      output inst_ready
   );
endinterface : ifu_inst_if

// File: rtl/ifu_inst_queue.sv
// -----------------------------------------------------------------------------
// ifu_inst_queue
// Synchronous FIFO holding fetched {pc, inst} entries for decode.
//   clk, rst      : clock, synchronous active-high reset
//   i_flush       : empty the queue (redirect); overrides push and pop
//   i_push        : write i_push_data at the tail
//   i_pop         : remove the head (ignored when empty)
//   o_head        : head entry (contents undefined when empty)
//   o_count       : number of valid entries, 0..DEPTH
//   o_full/o_empty: occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module ifu_inst_queue
   import ifu_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = q_entry_t,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_flush,
   input  logic          i_push,
   input  T              i_push_data,
   input  logic          i_pop,
   output T              o_head,
   output logic [CW-1:0] o_count,
   output logic          o_full,
   output logic          o_empty
);

   T              r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic w_push;
   logic w_pop;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_count = r_count;
   assign o_head  = r_mem[r_rd_ptr];

   assign w_push = i_push && !i_flush;
   assign w_pop  = i_pop  && !i_flush && !o_empty;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // NOTE: the storage array has no reset; occupancy is tracked by r_count,
   // so stale contents are never observed and the RAM stays reset-free.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_push_data;
   end

endmodule : ifu_inst_queue

// File: rtl/ifu_prefetch.sv
// -----------------------------------------------------------------------------
// ifu_prefetch
// Decoupled instruction fetch: issues in-order memory requests with up to
// MAX_OUTSTANDING in flight, buffers responses in a DEPTH-entry queue and
// presents the head to decode over valid/ready. Redirects flush the queue and
// mark every in-flight request as stale so its response is discarded.
//   clk, rst            : clock, synchronous active-high reset
//   br_taken/br_target  : branch redirect
//   ex/ex_entry         : exception redirect (highest priority)
//   ex_ret/epc          : mret redirect
//   imem (master)       : memory request/response port
//   dec  (master)       : decode port; inst/pc read 0 when the queue is empty
//   nextpc              : current fetch address
// XLEN/ILEN must match ifu_pkg, whose q_entry_t defines the queue entry.
// -----------------------------------------------------------------------------
module ifu_prefetch #(
   parameter int              XLEN            = ifu_pkg::XLEN,
   parameter int              ILEN            = ifu_pkg::ILEN,
   parameter int              DEPTH           = 4,
   parameter int              MAX_OUTSTANDING = 4,
   parameter logic [XLEN-1:0] RESET_PC        = ifu_pkg::RESET_PC
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            br_taken,
   input  logic [XLEN-1:0] br_target,
   input  logic            ex,
   input  logic [XLEN-1:0] ex_entry,
   input  logic            ex_ret,
   input  logic [XLEN-1:0] epc,
   ifu_imem_if.master      imem,
   ifu_inst_if.master      dec,
   output logic [XLEN-1:0] nextpc
);
   import ifu_pkg::*;

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
   // Wide enough to hold count + live requests without overflow.
   localparam int SW = ((CW > OW) ? CW : OW) + 1;

   // Architectural state
   logic [XLEN-1:0] r_fetch_pc;
   logic [XLEN-1:0] r_tail_pc;     // PC of the next live response to arrive
   logic [OW-1:0]   r_outstanding;
   logic [OW-1:0]   r_drop_cnt;    // stale responses still to discard

   // Redirect muxing
   redir_e          w_cause;
   logic            w_redirect;
   logic [XLEN-1:0] w_target;

   // Credit / handshake
   logic [OW-1:0]   w_live;
   logic [SW-1:0]   w_used;
   logic            w_req_valid;
   logic            w_fire;
   logic            w_resp;
   logic            w_drop_now;
   logic            w_push;
   logic            w_pop;
   logic [OW-1:0]   w_out_next;

   // Queue
   q_entry_t        w_push_data;
   q_entry_t        w_head;
   logic [CW-1:0]   w_count;
   logic            w_full;
   logic            w_empty;

   assign w_cause    = redir_cause(ex, ex_ret, br_taken);
   assign w_redirect = (w_cause != REDIR_NONE);

   // NOTE: every variable written in always_comb gets a default first so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      w_target = '0;
      unique case (w_cause)
         REDIR_EX:   w_target = ex_entry;
         REDIR_ERET: w_target = epc;
         REDIR_BR:   w_target = br_target;
         default:    w_target = '0;
      endcase
      w_target[1:0] = 2'b00;
   end

   // Every request that is not stale owns a queue slot in advance, so a
   // response can always be pushed without checking for space.
   assign w_live      = r_outstanding - r_drop_cnt;
   assign w_used      = SW'(w_count) + SW'(w_live);
   assign w_req_valid = !rst && !w_redirect
                        && (r_outstanding < OW'(MAX_OUTSTANDING))
                        && (w_used < SW'(DEPTH));
   assign w_fire      = w_req_valid && imem.req_ready;

   assign w_resp      = imem.resp_valid && !rst;
   assign w_drop_now  = w_resp && (r_drop_cnt != '0);
   assign w_push      = w_resp && !w_redirect && (r_drop_cnt == '0);
   assign w_pop       = !w_empty && dec.inst_ready && !w_redirect;

   assign w_out_next  = r_outstanding + OW'(w_fire) - OW'(w_resp);

   always_comb begin
      w_push_data      = '0;
      w_push_data.pc   = r_tail_pc;
      w_push_data.inst = imem.resp_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_pc    <= RESET_PC;
         r_tail_pc     <= RESET_PC;
         r_outstanding <= '0;
         r_drop_cnt    <= '0;
      end else begin
         r_outstanding <= w_out_next;
         if (w_redirect) begin
            // Everything still in flight after this cycle is stale.
            r_fetch_pc <= w_target;
            r_tail_pc  <= w_target;
            r_drop_cnt <= r_outstanding - OW'(w_resp);
         end else begin
            if (w_fire)     r_fetch_pc <= r_fetch_pc + XLEN'(4);
            if (w_push)     r_tail_pc  <= r_tail_pc + XLEN'(4);
            if (w_drop_now) r_drop_cnt <= r_drop_cnt - OW'(1);
         end
      end
   end

   ifu_inst_queue #(
      .DEPTH (DEPTH),
      .T     (q_entry_t)
   ) u_queue (
      .clk         (clk),
      .rst         (rst),
      .i_flush     (w_redirect),
      .i_push      (w_push),
      .i_push_data (w_push_data),
      .i_pop       (w_pop),
      .o_head      (w_head),
      .o_count     (w_count),
      .o_full      (w_full),
      .o_empty     (w_empty)
   );

   assign imem.req_valid = w_req_valid;
   assign imem.req_addr  = r_fetch_pc;
   assign nextpc         = r_fetch_pc;

   assign dec.inst_valid = !w_empty;
   assign dec.inst       = w_empty ? '0 : w_head.inst;
   assign dec.pc         = w_empty ? '0 : w_head.pc;

   // Credit rule guarantees a free slot for every live response.
   a_no_push_full : assert property (@(posedge clk) disable iff (rst)
      !(w_push && w_full));
   a_resp_has_req : assert property (@(posedge clk) disable iff (rst)
      !(imem.resp_valid && (r_outstanding == '0)));
   a_drop_le_out  : assert property (@(posedge clk) disable iff (rst)
      (r_drop_cnt <= r_outstanding));

endmodule : ifu_prefetch
